// File: rtl/perceptron_mac_if.sv
// perceptron_mac_if
//   Handshake bundle for the perceptron classifier.
//   Weight-load channel : wld_valid/wld_ready, wld_class, wld_feat, wld_shift, wld_sign
//   Feature input       : in_valid/in_ready, in_feat (feature i at [i*FEAT_W +: FEAT_W])
//   Result output       : out_valid/out_ready, out_class, out_score (signed)
//   master = producer of weights/features and consumer of results; slave = the classifier.
interface perceptron_mac_if #(
  parameter int FEAT_W  = 4,
  parameter int N_FEAT  = 7,
  parameter int FIDX_W  = 3,
  parameter int CLS_W   = 4,
  parameter int SHIFT_W = 3,
  parameter int ACC_W   = 16
);
  logic                       wld_valid;
  logic                       wld_ready;
  logic [CLS_W-1:0]           wld_class;
  logic [FIDX_W-1:0]          wld_feat;
  logic [SHIFT_W-1:0]         wld_shift;
  logic                       wld_sign;
  logic                       in_valid;
  logic                       in_ready;
  logic [N_FEAT*FEAT_W-1:0]   in_feat;
  logic                       out_valid;
  logic                       out_ready;
  logic [CLS_W-1:0]           out_class;
  logic [ACC_W-1:0]           out_score;

  modport master (
    output wld_valid, wld_class, wld_feat, wld_shift, wld_sign,
    output in_valid, in_feat, out_ready,
    input  wld_ready, in_ready, out_valid, out_class, out_score
  );

  modport slave (
    input  wld_valid, wld_class, wld_feat, wld_shift, wld_sign,
    input  in_valid, in_feat, out_ready,
    output wld_ready, in_ready, out_valid, out_class, out_score
  );
endinterface

// File: rtl/perceptron_mac.sv
// perceptron_mac
//   Sequential multi-class perceptron. One feature vector is scored against N_CLASS rows of
//   shift-only weights (+/-2^k) by a single shift/add datapath stepping class x feature, one
//   term per cycle. The strictly greatest score wins, so ties go to the lowest class index.
// Ports
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset (also clears the weight regfile)
//   bus  : perceptron_mac_if.slave -- weight-load, feature-input and result handshakes
module perceptron_mac #(
  parameter int FEAT_W  = 4,
  parameter int N_FEAT  = 7,
  parameter int FIDX_W  = 3,
  parameter int N_CLASS = 10,
  parameter int CLS_W   = 4,
  parameter int SHIFT_W = 3,
  parameter int ACC_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  perceptron_mac_if.slave   bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic signed [ACC_W-1:0] SCORE_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t                    state_r;
  logic [SHIFT_W-1:0]        wshift_r [N_CLASS][N_FEAT];
  logic                      wsign_r  [N_CLASS][N_FEAT];
  logic [N_FEAT*FEAT_W-1:0]  feat_r;
  logic [CLS_W-1:0]          cls_r;
  logic [CLS_W-1:0]          best_cls_r;
  logic [CLS_W-1:0]          out_class_r;
  logic [FIDX_W-1:0]         fi_r;
  logic signed [ACC_W-1:0]   acc_r;
  logic signed [ACC_W-1:0]   best_r;
  logic signed [ACC_W-1:0]   out_score_r;
  logic                      in_ready_r;
  logic                      wld_ready_r;
  logic                      out_valid_r;

  logic [FEAT_W-1:0]         fval_s;
  logic [SHIFT_W-1:0]        sh_s;
  logic                      sg_s;
  logic signed [ACC_W-1:0]   mag_s;
  logic signed [ACC_W-1:0]   term_s;
  logic signed [ACC_W-1:0]   acc_n_s;
  logic                      win_s;
  logic                      wr_en_s;

  assign bus.wld_ready = wld_ready_r;
  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_class = out_class_r;
  assign bus.out_score = out_score_r;

  // Shared datapath: one signed shift term per cycle plus the running-sum compare
  always_comb begin
    fval_s  = feat_r[fi_r*FEAT_W +: FEAT_W];
    sh_s    = wshift_r[cls_r][fi_r];
    sg_s    = wsign_r[cls_r][fi_r];
    mag_s   = ACC_W'(fval_s) << sh_s;
    if (sg_s) begin
      term_s = -mag_s;
    end else begin
      term_s = mag_s;
    end
    acc_n_s = acc_r + term_s;
    win_s   = (acc_n_s > best_r);
    // Out-of-range rows/columns are silently dropped
    wr_en_s = bus.wld_valid & wld_ready_r
            & (32'(bus.wld_class) < 32'(N_CLASS))
            & (32'(bus.wld_feat) < 32'(N_FEAT));
  end

  // Weight regfile: cleared to +1 on reset, written only while idle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < N_CLASS; c++) begin
        for (int f = 0; f < N_FEAT; f++) begin
          wshift_r[c][f] <= {SHIFT_W{1'b0}};
          wsign_r[c][f]  <= 1'b0;
        end
      end
    end else if (wr_en_s) begin
      wshift_r[bus.wld_class][bus.wld_feat] <= bus.wld_shift;
      wsign_r[bus.wld_class][bus.wld_feat]  <= bus.wld_sign;
    end
  end

  // Control FSM with registered handshake outputs and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      wld_ready_r <= 1'b1;
      out_valid_r <= 1'b0;
      out_class_r <= {CLS_W{1'b0}};
      out_score_r <= {ACC_W{1'b0}};
      feat_r      <= {(N_FEAT*FEAT_W){1'b0}};
      cls_r       <= {CLS_W{1'b0}};
      fi_r        <= {FIDX_W{1'b0}};
      acc_r       <= {ACC_W{1'b0}};
      best_r      <= {ACC_W{1'b0}};
      best_cls_r  <= {CLS_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            feat_r      <= bus.in_feat;
            cls_r       <= {CLS_W{1'b0}};
            fi_r        <= {FIDX_W{1'b0}};
            acc_r       <= {ACC_W{1'b0}};
            best_r      <= SCORE_MIN;
            best_cls_r  <= {CLS_W{1'b0}};
            in_ready_r  <= 1'b0;
            wld_ready_r <= 1'b0;
            state_r     <= CALC;
          end
        end
        CALC: begin
          if (fi_r == FIDX_W'(N_FEAT-1)) begin
            acc_r <= {ACC_W{1'b0}};
            fi_r  <= {FIDX_W{1'b0}};
            if (win_s) begin
              best_r     <= acc_n_s;
              best_cls_r <= cls_r;
            end
            if (cls_r == CLS_W'(N_CLASS-1)) begin
              // Publish the final winner directly, including this last row's update
              out_class_r <= win_s ? cls_r : best_cls_r;
              out_score_r <= win_s ? acc_n_s : best_r;
              out_valid_r <= 1'b1;
              state_r     <= DONE;
            end else begin
              cls_r <= cls_r + CLS_W'(1);
            end
          end else begin
            acc_r <= acc_n_s;
            fi_r  <= fi_r + FIDX_W'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            wld_ready_r <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          wld_ready_r <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_perceptron_mac.sv
// tb_perceptron_mac
//   Directed bench for perceptron_mac. A behavioural model (integer sums per class, strict argmax)
//   predicts each result; a negedge compare process checks out_class/out_score whenever
//   out_valid is high, and literal expectations pin the model on hand-computed cases.
module tb_perceptron_mac;
  localparam int FEAT_W  = 4;
  localparam int N_FEAT  = 7;
  localparam int FIDX_W  = 3;
  localparam int N_CLASS = 10;
  localparam int CLS_W   = 4;
  localparam int SHIFT_W = 3;
  localparam int ACC_W   = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  perceptron_mac_if #(
    .FEAT_W(FEAT_W), .N_FEAT(N_FEAT), .FIDX_W(FIDX_W),
    .CLS_W(CLS_W), .SHIFT_W(SHIFT_W), .ACC_W(ACC_W)
  ) bus ();

  perceptron_mac #(
    .FEAT_W(FEAT_W), .N_FEAT(N_FEAT), .FIDX_W(FIDX_W), .N_CLASS(N_CLASS),
    .CLS_W(CLS_W), .SHIFT_W(SHIFT_W), .ACC_W(ACC_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int m_shift [N_CLASS][N_FEAT];
  int m_sign  [N_CLASS][N_FEAT];
  int exp_class = 0;
  int exp_score = 0;
  int cyc = 0;
  int acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Result compare against the model on every cycle a result is presented
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      chk("out_class", int'(bus.out_class), exp_class);
      chk("out_score", int'($signed(bus.out_score)), exp_score);
      chk("in_ready_busy", int'(bus.in_ready), 0);
    end
  end

  task automatic model_reset();
    for (int c = 0; c < N_CLASS; c++)
      for (int f = 0; f < N_FEAT; f++) begin
        m_shift[c][f] = 0;
        m_sign[c][f]  = 0;
      end
  endtask

  // Score every class with plain integer arithmetic; strict > keeps lowest index on ties
  task automatic model(input logic [N_FEAT*FEAT_W-1:0] fv);
    int best;
    int bc;
    int s;
    int v;
    best = -32768;
    bc   = 0;
    for (int c = 0; c < N_CLASS; c++) begin
      s = 0;
      for (int f = 0; f < N_FEAT; f++) begin
        v = int'(fv[f*FEAT_W +: FEAT_W]) * (1 << m_shift[c][f]);
        s = (m_sign[c][f] != 0) ? s - v : s + v;
      end
      if (s > best) begin
        best = s;
        bc   = c;
      end
    end
    exp_class = bc;
    exp_score = best;
  endtask

  task automatic wr(input int c, input int f, input int sh, input int sg);
    @(negedge clk);
    bus.wld_valid = 1'b1;
    bus.wld_class = CLS_W'(c);
    bus.wld_feat  = FIDX_W'(f);
    bus.wld_shift = SHIFT_W'(sh);
    bus.wld_sign  = sg[0];
    chk("wld_ready_idle", int'(bus.wld_ready), 1);
    @(posedge clk);
    #1;
    bus.wld_valid = 1'b0;
    if (c < N_CLASS && f < N_FEAT) begin
      m_shift[c][f] = sh;
      m_sign[c][f]  = sg;
    end
  endtask

  task automatic accept(input logic [N_FEAT*FEAT_W-1:0] fv);
    @(negedge clk);
    model(fv);
    chk("in_ready_idle", int'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_feat  = fv;
    @(posedge clk);
    #1;
    acc_cyc      = cyc;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("out_valid_seen", int'(bus.out_valid === 1'b1), 1);
    chk("latency", cyc - acc_cyc, N_CLASS * N_FEAT);
  endtask

  task automatic drain();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("out_valid_clear", int'(bus.out_valid), 0);
    chk("in_ready_back", int'(bus.in_ready), 1);
  endtask

  task automatic run(input logic [N_FEAT*FEAT_W-1:0] fv);
    accept(fv);
    wait_done();
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.wld_valid = 1'b0;
    bus.wld_class = '0;
    bus.wld_feat  = '0;
    bus.wld_shift = '0;
    bus.wld_sign  = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_feat   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_wld_ready", int'(bus.wld_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_class", int'(bus.out_class), 0);
    chk("rst_out_score", int'($signed(bus.out_score)), 0);

    // All +1 weights, all features 1: every class scores 7, tie goes to class 0
    accept(28'h1111111);
    wait_done();
    chk("c1_class", int'(bus.out_class), 0);
    chk("c1_score", int'($signed(bus.out_score)), 7);
    drain();

    // All -1 weights: all classes tie at -7, still class 0
    for (int c = 0; c < N_CLASS; c++)
      for (int f = 0; f < N_FEAT; f++)
        wr(c, f, 0, 1);
    accept(28'h1111111);
    wait_done();
    chk("neg_class", int'(bus.out_class), 0);
    chk("neg_score", int'($signed(bus.out_score)), -7);
    drain();

    // Class 3 feature 0 = +16, feature 0 = 15: 240 wins; then hold the result
    wr(3, 0, 4, 0);
    accept(28'h000000F);
    wait_done();
    chk("c2_class", int'(bus.out_class), 3);
    chk("c2_score", int'($signed(bus.out_score)), 240);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold_valid", int'(bus.out_valid), 1);
      chk("hold_class", int'(bus.out_class), 3);
      chk("hold_score", int'($signed(bus.out_score)), 240);
    end
    drain();

    // Weight write attempted mid-CALC must be refused
    accept(28'h000000F);
    repeat (5) @(posedge clk);
    @(negedge clk);
    bus.wld_valid = 1'b1;
    bus.wld_class = 4'd3;
    bus.wld_feat  = 3'd0;
    bus.wld_shift = 3'd0;
    bus.wld_sign  = 1'b0;
    chk("calc_wld_ready", int'(bus.wld_ready), 0);
    @(posedge clk);
    #1;
    bus.wld_valid = 1'b0;
    wait_done();
    drain();
    run(28'h000000F);
    chk("c4_model_score", exp_score, 240);

    // Out-of-range writes are dropped
    wr(12, 0, 0, 0);
    wr(3, 7, 0, 0);
    accept(28'h000000F);
    wait_done();
    chk("c5_class", int'(bus.out_class), 3);
    chk("c5_score", int'($signed(bus.out_score)), 240);
    drain();

    // Mixed weights, checked against the model only
    for (int c = 0; c < N_CLASS; c++)
      for (int f = 0; f < N_FEAT; f++)
        wr(c, f, (c * 3 + f) % 8, ((c + f) % 3 == 0) ? 1 : 0);
    run(28'h9A3F1C7);
    run(28'h7777777);
    run(28'h0F0F0F0);
    run(28'hFFFFFFF);

    // Reset in the middle of CALC aborts and clears weights
    accept(28'h1111111);
    repeat (30) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    chk("abort_out_valid", int'(bus.out_valid), 0);
    chk("abort_in_ready", int'(bus.in_ready), 1);
    chk("abort_wld_ready", int'(bus.wld_ready), 1);
    accept(28'h1111111);
    wait_done();
    chk("c6_class", int'(bus.out_class), 0);
    chk("c6_score", int'($signed(bus.out_score)), 7);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
